// File: rtl/timeout_event_collector_if.sv
// Event handshake between the timeout collector (master) and its single consumer (slave).
interface timeout_event_collector_if #(
  parameter int unsigned IDX_W = 3
);
  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_idx;

  modport master (output evt_valid, output evt_idx, input  evt_ready);
  modport slave  (input  evt_valid, input  evt_idx, output evt_ready);
endinterface

// File: rtl/timeout_event_collector.sv
// Captures rising edges of per-timer time_out flags, arbitrates them round-robin into a
// small index FIFO drained over a valid/ready handshake, and counts lost events.
module timeout_event_collector #(
  parameter  int unsigned TIMER_NUM  = 5,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned IDX_W      = $clog2(TIMER_NUM),
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TIMER_NUM-1:0]     time_out,
  timeout_event_collector_if.master evt,
  output logic [TIMER_NUM-1:0]     pending,
  output logic [LVL_W-1:0]         fifo_level,
  output logic [7:0]               drop_cnt
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [TIMER_NUM-1:0] prev;
  logic [TIMER_NUM-1:0] rise;
  logic [TIMER_NUM-1:0] gnt_oh;
  logic [TIMER_NUM-1:0] drops;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt;
  logic                 pop;
  logic [8:0]           drop_sum;
  logic [IDX_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  always_comb begin : arb
    int unsigned cand;
    cand    = 0;
    rise    = time_out & ~prev;
    gnt     = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    // Full check uses the pre-pop level, so a full FIFO never takes a push this cycle.
    if (fifo_level < LVL_W'(FIFO_DEPTH)) begin
      for (int unsigned j = 0; j < TIMER_NUM; j++) begin
        cand = 32'(rr_ptr) + j;
        if (cand >= TIMER_NUM) cand = cand - TIMER_NUM;
        if (!gnt && pending[cand]) begin
          gnt     = 1'b1;
          gnt_idx = IDX_W'(cand);
        end
      end
    end
    if (gnt) gnt_oh[gnt_idx] = 1'b1;
  end

  always_comb begin
    pop      = (fifo_level != '0) & evt.evt_ready;
    drops    = rise & pending & ~gnt_oh;
    drop_sum = {1'b0, drop_cnt};
    for (int unsigned i = 0; i < TIMER_NUM; i++) begin
      drop_sum = drop_sum + 9'(drops[i]);
    end
  end

  assign evt.evt_valid = (fifo_level != '0);
  assign evt.evt_idx   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      pending    <= '0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_cnt   <= '0;
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      prev    <= time_out;
      // A new rise on the granted bit re-arms it: set wins over clear.
      pending <= (pending & ~gnt_oh) | rise;
      if (gnt) begin
        mem[wr_ptr] <= gnt_idx;
        wr_ptr      <= wr_ptr + PTR_W'(1);
        rr_ptr      <= (gnt_idx == IDX_W'(TIMER_NUM - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({gnt, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end
  end
endmodule
